// File: rtl/fetch_sequencer.sv
// PC driver and fetch sequencer for a single-outstanding, variable-latency instruction memory.
// Optional build macro FETCH_STAT_EN adds saturating stall_cycles / flush_count statistics outputs.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  input  logic               hazard_detected,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_value,
  output logic               instr_valid
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_HAZ, DISCARD} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  redirect;
  logic [INSTR_W-1:0] skid;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  pc_inc;
  logic               unused_addr_lsb;

  // Word alignment: the two low bits of a redirect target are forced to zero.
  assign target          = {branch_address[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^branch_address[1:0];
  assign pc_inc          = pc + STEP;

  // In DISCARD the request stays on the old pc until the memory answers.
  assign mem_req  = (state == FETCH) || (state == DISCARD);
  assign mem_addr = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redirect    <= '0;
      skid        <= '0;
      instruction <= '0;
      pc_value    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (mem_ready && branch_taken) begin
            pc          <= target;
            instr_valid <= 1'b0;
          end else if (mem_ready && hazard_detected) begin
            skid  <= mem_rdata;
            state <= WAIT_HAZ;
          end else if (mem_ready) begin
            instruction <= mem_rdata;
            pc_value    <= pc_inc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
          end else if (branch_taken) begin
            redirect    <= target;
            instr_valid <= 1'b0;
            state       <= DISCARD;
          end else if (!hazard_detected) begin
            instr_valid <= 1'b0;
          end
        end
        WAIT_HAZ: begin
          if (branch_taken) begin
            pc          <= target;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (!hazard_detected) begin
            instruction <= skid;
            pc_value    <= pc_inc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          instr_valid <= 1'b0;
          if (branch_taken) redirect <= target;
          if (mem_ready) begin
            pc    <= branch_taken ? target : redirect;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STAT_EN
  logic stall_evt;
  logic flush_evt;

  // A stall cycle is any edge that loads a bubble or holds outputs for a hazard.
  always_comb begin
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    case (state)
      FETCH: begin
        stall_evt = !(mem_ready && !branch_taken && !hazard_detected);
        flush_evt = branch_taken;
      end
      WAIT_HAZ: begin
        stall_evt = branch_taken || hazard_detected;
        flush_evt = branch_taken;
      end
      DISCARD: begin
        stall_evt = 1'b1;
        flush_evt = branch_taken;
      end
      default: begin
        stall_evt = 1'b0;
        flush_evt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt && (flush_count != '1))  flush_count  <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed test-plan sequences, then random traffic vs a transaction-level model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        hazard_detected = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] pc_value;
  logic        instr_valid;
`ifdef FETCH_STAT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  fetch_sequencer dut (
    .clock(clock), .reset(reset),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .hazard_detected(hazard_detected),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instruction(instruction), .pc_value(pc_value), .instr_valid(instr_valid)
`ifdef FETCH_STAT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic req; logic [31:0] addr; } mem_exp_t;
  typedef struct { logic [31:0] instr; logic [31:0] pcv; logic vld; logic [31:0] stall; logic [15:0] flush; } out_exp_t;

  mem_exp_t mq[$];
  out_exp_t oq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tracks the fetch stream as "started", "word parked", "response owed to discard".
  bit          m_run, m_held, m_disc, m_vld;
  logic [31:0] m_pc, m_tgt, m_buf, m_instr, m_pcv;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_held = 0; m_disc = 0; m_vld = 0;
    m_pc = 32'h0; m_tgt = '0; m_buf = '0; m_instr = '0; m_pcv = '0;
    m_stall = '0; m_flush = '0;
  endtask

  task automatic deliver(input logic [31:0] word);
    m_instr = word;
    m_pc    = m_pc + 32'd4;
    m_pcv   = m_pc;
    m_vld   = 1;
  endtask

  // Called at a negedge: drive one cycle of stimulus, record expectations, advance to the next negedge.
  task automatic cycle(input bit bt, input logic [31:0] ba, input bit hz, input bit rdy, input logic [31:0] rd);
    mem_exp_t    me;
    out_exp_t    oe;
    bit          req, stall, active;
    logic [31:0] t;
    req    = m_run && !m_held;
    active = m_run;
    branch_taken    = bt;
    branch_address  = ba;
    hazard_detected = hz;
    mem_ready       = rdy && req;
    mem_rdata       = rd;
    me.req = req; me.addr = m_pc;
    mq.push_back(me);
    t = ba & ~32'h3;
    stall = 0;
    if (!m_run) m_run = 1;
    else if (m_held) begin
      if (bt) begin m_pc = t; m_held = 0; m_vld = 0; stall = 1; end
      else if (!hz) begin m_held = 0; deliver(m_buf); end
      else stall = 1;
    end else if (m_disc) begin
      stall = 1; m_vld = 0;
      if (bt) m_tgt = t;
      if (rdy) begin m_pc = m_tgt; m_disc = 0; end
    end else begin
      if (rdy && bt) begin m_pc = t; m_vld = 0; stall = 1; end
      else if (rdy && hz) begin m_buf = rd; m_held = 1; stall = 1; end
      else if (rdy) deliver(rd);
      else if (bt) begin m_tgt = t; m_disc = 1; m_vld = 0; stall = 1; end
      else if (hz) stall = 1;
      else begin m_vld = 0; stall = 1; end
    end
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (active && bt && m_flush != 16'hFFFF) m_flush++;
    oe.instr = m_instr; oe.pcv = m_pcv; oe.vld = m_vld; oe.stall = m_stall; oe.flush = m_flush;
    oq.push_back(oe);
    @(negedge clock);
  endtask

  // Monitor: combinational fetch request, checked mid-cycle.
  initial forever begin
    mem_exp_t e;
    @(negedge clock); #2;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      check("mem_req", {31'b0, mem_req}, {31'b0, e.req});
      if (e.req) check("mem_addr", mem_addr, e.addr);
    end
  end

  // Monitor: registered IF/ID outputs, checked just after the edge.
  initial forever begin
    out_exp_t e;
    @(posedge clock); #1;
    if (oq.size() > 0) begin
      e = oq.pop_front();
      check("instr_valid", {31'b0, instr_valid}, {31'b0, e.vld});
      check("instruction", instruction, e.instr);
      check("pc_value", pc_value, e.pcv);
`ifdef FETCH_STAT_EN
      check("stall_cycles", stall_cycles, e.stall);
      check("flush_count", {16'b0, flush_count}, {16'b0, e.flush});
`endif
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_instruction"}, instruction, 32'd0);
    check({tag, "_pc_value"}, pc_value, 32'd0);
    check({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_STAT_EN
    check({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    check({tag, "_flush_count"}, {16'b0, flush_count}, 32'd0);
`endif
  endtask

  initial begin
    model_reset();
    #3;
    check_reset_values("rst");
    @(negedge clock);
    reset = 1'b1;

    // Zero-wait stream, then skid hazard at pc 0x10 returning 0x1234.
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'(i*4) ^ 32'hA5A5A5A5);
    cycle(0, 0, 1, 1, 32'h1234);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, $urandom);
    cycle(0, 0, 0, 0, $urandom);
    cycle(0, 0, 0, 1, $urandom);

    // Redirect during a wait state at pc 0x20, target 0x103.
    cycle(1, 32'h20, 0, 1, $urandom);
    cycle(0, 0, 0, 0, $urandom);
    cycle(1, 32'h103, 0, 0, $urandom);
    cycle(0, 0, 0, 0, $urandom);
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);

    // Branch and hazard together with ready: branch wins.
    cycle(1, 32'h40, 1, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);

    // Wait states: ready every third cycle.
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, (i % 3) == 2, $urandom);

    // Address wrap past the top of memory.
    cycle(1, 32'hFFFF_FFFB, 0, 1, $urandom);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, $urandom);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom);

    // Drain to a plain fetch, park in DISCARD, then reset asynchronously.
    for (int i = 0; i < 8 && !(m_run && !m_held && !m_disc); i++) cycle(0, 0, 0, 1, $urandom);
    cycle(1, 32'h200, 0, 0, $urandom);
    cycle(0, 0, 0, 0, $urandom);
    branch_taken = 0; hazard_detected = 0; mem_ready = 0;
    #1;
    check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("mid_rst");
    model_reset();
    mq.delete();
    oq.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, $urandom);

    @(posedge clock); #3;
    check("mq_drained", mq.size(), 32'd0);
    check("oq_drained", oq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller that drives the PC and sequences instruction fetches from a variable-latency, single-outstanding instruction memory (req/ready handshake). Sits between the branch/hazard logic and the IF/ID pipeline register. It applies branch redirects and downstream stalls, including redirects that arrive while a fetch is still outstanding. Throughput is one instruction per cycle when the memory answers in the request cycle.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
branch_taken  input  1  redirect request from branch resolution
branch_address  input  ADDR_W  redirect target; bits [1:0] ignored and treated as 0
hazard_detected  input  1  downstream stall; IF outputs must hold
mem_req  output  1  fetch request to instruction memory
mem_addr  output  ADDR_W  fetch address; stable while mem_req=1
mem_ready  input  1  memory response strobe; mem_rdata valid in the same cycle
mem_rdata  input  INSTR_W  fetched word
instruction  output  INSTR_W  instruction to IF/ID
pc_value  output  ADDR_W  PC+4 of the presented instruction
instr_valid  output  1  instruction is real (0 = bubble)

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, redirect=0, buf=0, mem_req=0, instruction=0, pc_value=0, instr_valid=0.
- States: IDLE, FETCH, WAIT_HAZ, DISCARD. Outputs are registered except mem_req and mem_addr, which are decoded from the state.
- IDLE: mem_req=0. Moves to FETCH on the first edge after reset release.
- FETCH: mem_req=1, mem_addr=pc. At each edge, the first matching row applies:
  - mem_ready & branch_taken: pc<=branch_address. Response dropped. instr_valid<=0. Stay in FETCH.
  - mem_ready & hazard_detected: buf<=mem_rdata. pc unchanged. Outputs held. Go to WAIT_HAZ.
  - mem_ready: instruction<=mem_rdata, pc_value<=pc+4, instr_valid<=1, pc<=pc+4.
  - !mem_ready & branch_taken: redirect<=branch_address. instr_valid<=0. Go to DISCARD.
  - !mem_ready & hazard_detected: all outputs held.
  - !mem_ready: instr_valid<=0 (bubble).
- WAIT_HAZ: mem_req=0.
  - branch_taken: pc<=branch_address, buf discarded, instr_valid<=0, go to FETCH.
  - else !hazard_detected: instruction<=buf, pc_value<=pc+4, instr_valid<=1, pc<=pc+4, go to FETCH.
  - else: hold.
- DISCARD: mem_req=1, mem_addr=old pc (a request is never withdrawn or changed before ready). instr_valid=0.
  - A further branch_taken overwrites redirect (last wins).
  - On mem_ready: response dropped, pc<=redirect (or branch_address if branch_taken in the same cycle), go to FETCH.
- Priority: branch_taken over hazard_detected, in every state.
- PC arithmetic: modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0. pc[1:0] is always 0.
- Reset asserted mid-transaction: everything returns to reset values immediately. The memory must tolerate mem_req dropping asynchronously.

Optional Feature:
FETCH_STAT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_count[15:0].
  - stall_cycles increments every cycle that instr_valid<=0 is loaded, or that outputs are held because of hazard_detected.
  - flush_count increments on each accepted branch_taken.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Zero-wait stream: mem_ready tied 1, mem_rdata=addr^0xA5A5A5A5. After reset: mem_addr 0,4,8,... on consecutive cycles, instr_valid=1 from the 2nd edge, pc_value=4,8,12.
- Wait states: mem_ready high every 3rd cycle. mem_addr stable across wait cycles, instr_valid=1 one cycle in three, no address skipped.
- Hazard with skid: assert hazard_detected for 4 cycles on the cycle mem_ready returns word 0x1234 at pc 0x10. Outputs hold for 4 cycles. Then instruction=0x1234, pc_value=0x14, next mem_addr=0x14.
- Redirect during wait: at pc 0x20 with mem_ready low, pulse branch_taken with branch_address=0x103. mem_addr stays 0x20 until ready, that response is dropped (instr_valid=0), next mem_addr=0x100.
- Simultaneous branch and hazard in FETCH with mem_ready=1, target 0x40: branch wins, next mem_addr=0x40, instr_valid=0.
- Async reset mid-DISCARD: mem_req drops immediately, all outputs 0. After release, first mem_addr=RESET_PC. With FETCH_STAT_EN defined, both counters read 0.
